// File: rtl/osd_spi_sequencer_if.sv
// Signal bundle between osd_spi_sequencer, its two requesters, the data byte source and the OSD SPI port.
// With OSD_SEQ_ABORT_EN defined the bundle also carries abort / wr_aborted.
interface osd_spi_sequencer_if;
    logic       en_req;
    logic       en_val;
    logic       en_ack;
    logic       wr_req;
    logic [3:0] wr_line;
    logic       wr_ack;
    logic       rd_strobe;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       spi_sck;
    logic       spi_ss;
    logic       spi_do;
    logic       busy;
`ifdef OSD_SEQ_ABORT_EN
    logic       abort;
    logic       wr_aborted;

    modport master (
        input  en_req, en_val, wr_req, wr_line, rd_data, abort,
        output en_ack, wr_ack, rd_strobe, rd_addr, spi_sck, spi_ss, spi_do, busy, wr_aborted
    );
    modport slave (
        output en_req, en_val, wr_req, wr_line, rd_data, abort,
        input  en_ack, wr_ack, rd_strobe, rd_addr, spi_sck, spi_ss, spi_do, busy, wr_aborted
    );
`else
    modport master (
        input  en_req, en_val, wr_req, wr_line, rd_data,
        output en_ack, wr_ack, rd_strobe, rd_addr, spi_sck, spi_ss, spi_do, busy
    );
    modport slave (
        output en_req, en_val, wr_req, wr_line, rd_data,
        input  en_ack, wr_ack, rd_strobe, rd_addr, spi_sck, spi_ss, spi_do, busy
    );
`endif
endinterface

// File: rtl/osd_spi_sequencer.sv
// Local SPI master for the OSD command port: arbitrates enable (1 byte) and line-write (257 byte) requests.
// Optional early write termination is compiled in with OSD_SEQ_ABORT_EN.
module osd_spi_sequencer #(
    parameter int CLK_DIV = 2,
    parameter int SS_GAP  = 4
) (
    input  logic                clk_sys,
    input  logic                reset,
    osd_spi_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_e;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(SS_GAP - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [8:0] byte_q, byte_d;
    logic       is_wr_q, is_wr_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       fetch_q, fetch_d;
    logic       sck_q, sck_d;
    logic       ss_q, ss_d;
    logic       busy_q, busy_d;
    logic       en_ack_q, en_ack_d;
    logic       wr_ack_q, wr_ack_d;
    logic       rd_strobe_q, rd_strobe_d;
    logic [7:0] rd_addr_q, rd_addr_d;
    logic       last_byte;
    logic       stop_early;

`ifdef OSD_SEQ_ABORT_EN
    logic abort_q, abort_d;
    logic wr_aborted_q, wr_aborted_d;
    assign stop_early     = is_wr_q && (abort_q || bus.abort);
    assign bus.wr_aborted = wr_aborted_q;
`else
    assign stop_early = 1'b0;
`endif

    assign last_byte = (byte_q == (is_wr_q ? 9'd256 : 9'd0));

    always_comb begin
        // NOTE: every next-state value is defaulted first so no path through this block infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        is_wr_d     = is_wr_q;
        shift_d     = shift_q;
        hold_d      = fetch_q ? bus.rd_data : hold_q;
        fetch_d     = rd_strobe_q;
        sck_d       = sck_q;
        ss_d        = ss_q;
        busy_d      = busy_q;
        en_ack_d    = 1'b0;
        wr_ack_d    = 1'b0;
        rd_strobe_d = 1'b0;
        rd_addr_d   = rd_addr_q;
`ifdef OSD_SEQ_ABORT_EN
        abort_d      = abort_q;
        wr_aborted_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.en_req || bus.wr_req) begin
                    state_d = SETUP;
                    cnt_d   = 8'd0;
                    bit_d   = 3'd0;
                    byte_d  = 9'd0;
                    busy_d  = 1'b1;
                    ss_d    = 1'b0;
                    is_wr_d = !bus.en_req;
                    shift_d = bus.en_req ? {4'h4, 3'b000, bus.en_val} : {4'h2, bus.wr_line};
                    if (!bus.en_req) begin
                        rd_strobe_d = 1'b1;
                        rd_addr_d   = 8'd0;
                    end
`ifdef OSD_SEQ_ABORT_EN
                    abort_d = 1'b0;
`endif
                end
            end
            SETUP: begin
`ifdef OSD_SEQ_ABORT_EN
                abort_d = stop_early;
`endif
                if (cnt_q == DIV_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SHIFT: begin
`ifdef OSD_SEQ_ABORT_EN
                abort_d = stop_early;
`endif
                if (cnt_q != DIV_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = 8'd0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        // First rise of each data byte prefetches the byte that follows it.
                        if (bit_q == 3'd0 && is_wr_q && byte_q != 9'd0 && !last_byte && !stop_early) begin
                            rd_strobe_d = 1'b1;
                            rd_addr_d   = byte_q[7:0];
                        end
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q != 3'd7) begin
                            bit_d   = bit_q + 3'd1;
                            shift_d = {shift_q[6:0], 1'b0};
                        end else if (last_byte || stop_early) begin
                            state_d  = GAP;
                            ss_d     = 1'b1;
                            shift_d  = 8'h00;
                            en_ack_d = !is_wr_q;
                            wr_ack_d = is_wr_q;
`ifdef OSD_SEQ_ABORT_EN
                            wr_aborted_d = stop_early;
`endif
                        end else begin
                            bit_d   = 3'd0;
                            byte_d  = byte_q + 9'd1;
                            shift_d = hold_q;
                        end
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            bit_q       <= 3'd0;
            byte_q      <= 9'd0;
            is_wr_q     <= 1'b0;
            shift_q     <= 8'h00;
            hold_q      <= 8'h00;
            fetch_q     <= 1'b0;
            sck_q       <= 1'b0;
            ss_q        <= 1'b1;
            busy_q      <= 1'b0;
            en_ack_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_strobe_q <= 1'b0;
            rd_addr_q   <= 8'd0;
`ifdef OSD_SEQ_ABORT_EN
            abort_q      <= 1'b0;
            wr_aborted_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            is_wr_q     <= is_wr_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            fetch_q     <= fetch_d;
            sck_q       <= sck_d;
            ss_q        <= ss_d;
            busy_q      <= busy_d;
            en_ack_q    <= en_ack_d;
            wr_ack_q    <= wr_ack_d;
            rd_strobe_q <= rd_strobe_d;
            rd_addr_q   <= rd_addr_d;
`ifdef OSD_SEQ_ABORT_EN
            abort_q      <= abort_d;
            wr_aborted_q <= wr_aborted_d;
`endif
        end
    end

    // The MSB of the shift register is the serial line, so DO moves only when the register does.
    assign bus.spi_do    = shift_q[7];
    assign bus.spi_sck   = sck_q;
    assign bus.spi_ss    = ss_q;
    assign bus.busy      = busy_q;
    assign bus.en_ack    = en_ack_q;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.rd_strobe = rd_strobe_q;
    assign bus.rd_addr   = rd_addr_q;
endmodule

// File: tb/tb_osd_spi_sequencer.sv
// Directed bench: a CLK_DIV=2 instance for function and arbitration, a CLK_DIV=5 instance for SCK/DO timing.
// Define OSD_SEQ_ABORT_EN to also exercise early write termination.
module tb_osd_spi_sequencer;
    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    osd_spi_sequencer_if bus2 ();
    osd_spi_sequencer_if bus5 ();

    osd_spi_sequencer #(.CLK_DIV(2), .SS_GAP(4)) dut2 (.clk_sys(clk_sys), .reset(reset), .bus(bus2));
    osd_spi_sequencer #(.CLK_DIV(5), .SS_GAP(4)) dut5 (.clk_sys(clk_sys), .reset(reset), .bus(bus5));

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Byte source: rd_data = rd_addr ^ 0x5A, valid from the middle of the strobe cycle onward.
    always @(negedge clk_sys) begin
        if (bus2.rd_strobe) bus2.rd_data = bus2.rd_addr ^ 8'h5A;
        if (bus5.rd_strobe) bus5.rd_data = bus5.rd_addr ^ 8'h5A;
    end

    // SPI slave model and event counters for the CLK_DIV=2 instance.
    int         rises2 = 0, strobes2 = 0, en_acks2 = 0, wr_acks2 = 0, ss_rises2 = 0, aborted2 = 0;
    int         bits2 = 0;
    logic [7:0] sr2 = 8'h00;
    logic       sck_prev2 = 1'b0, ss_prev2 = 1'b1;
    logic [7:0] bytes2 [$];
    always @(negedge clk_sys) begin
        if (bus2.spi_ss) begin
            bits2 = 0;
        end else if (bus2.spi_sck && !sck_prev2) begin
            rises2++;
            sr2 = {sr2[6:0], bus2.spi_do};
            bits2++;
            if (bits2 == 8) begin
                bytes2.push_back(sr2);
                bits2 = 0;
            end
        end
        if (bus2.spi_ss && !ss_prev2) ss_rises2++;
        sck_prev2 = bus2.spi_sck;
        ss_prev2  = bus2.spi_ss;
        if (bus2.rd_strobe) strobes2++;
        if (bus2.en_ack) en_acks2++;
        if (bus2.wr_ack) wr_acks2++;
`ifdef OSD_SEQ_ABORT_EN
        if (bus2.wr_aborted) aborted2++;
`endif
    end

    // Cycle 0 is the first cycle after the grant edge; returns ack and first idle cycle (-1 if not seen).
    task automatic watch2(input int limit, input bit drop_en, input bit drop_wr,
                          output int ack_cyc, output int idle_cyc);
        ack_cyc  = -1;
        idle_cyc = -1;
        for (int c = 0; c < limit && idle_cyc < 0; c++) begin
            @(negedge clk_sys);
            if (c == 0) begin
                if (drop_en) bus2.en_req = 1'b0;
                if (drop_wr) bus2.wr_req = 1'b0;
            end
            if ((bus2.en_ack || bus2.wr_ack) && ack_cyc < 0) ack_cyc = c;
            if (!bus2.busy) idle_cyc = c;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int ack, idle, b0, r0, s0, e0, w0, ss0, derr, bad, nr;
        logic sck_t [0:99];
        logic do_t  [0:99];
        logic ss_t  [0:99];

        bus2.en_req = 1'b0; bus2.en_val = 1'b0; bus2.wr_req = 1'b0; bus2.wr_line = 4'h0;
        bus5.en_req = 1'b0; bus5.en_val = 1'b0; bus5.wr_req = 1'b0; bus5.wr_line = 4'h0;
`ifdef OSD_SEQ_ABORT_EN
        bus2.abort = 1'b0;
        bus5.abort = 1'b0;
`endif
        repeat (3) @(negedge clk_sys);
        check("reset ss", bus2.spi_ss, 1);
        check("reset sck", bus2.spi_sck, 0);
        check("reset do", bus2.spi_do, 0);
        check("reset busy", bus2.busy, 0);
        check("reset acks", {bus2.en_ack, bus2.wr_ack}, 0);
        check("reset rd_strobe", bus2.rd_strobe, 0);
        check("reset rd_addr", bus2.rd_addr, 0);
        check("reset ss div5", bus5.spi_ss, 1);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Enable command 0x41.
        b0 = bytes2.size(); r0 = rises2; s0 = strobes2; e0 = en_acks2; w0 = wr_acks2;
        bus2.en_val = 1'b1; bus2.en_req = 1'b1;
        watch2(100, 1'b1, 1'b0, ack, idle);
        check("en ack cycle", ack, 34);
        check("en idle cycle", idle, 38);
        check("en sck rises", rises2 - r0, 8);
        check("en byte count", bytes2.size() - b0, 1);
        check("en cmd byte", bytes2[b0], 8'h41);
        check("en ack count", {en_acks2 - e0, wr_acks2 - w0}, {32'd1, 32'd0});
        check("en no strobes", strobes2 - s0, 0);
        repeat (3) @(negedge clk_sys);

        // Full line write, line 3.
        b0 = bytes2.size(); r0 = rises2; s0 = strobes2; w0 = wr_acks2; ss0 = ss_rises2;
        bus2.wr_line = 4'h3; bus2.wr_req = 1'b1;
        watch2(9000, 1'b0, 1'b1, ack, idle);
        check("wr ack cycle", ack, 8226);
        check("wr idle cycle", idle, 8230);
        check("wr sck rises", rises2 - r0, 2056);
        check("wr byte count", bytes2.size() - b0, 257);
        check("wr cmd byte", bytes2[b0], 8'h23);
        derr = 0;
        if (bytes2.size() >= b0 + 257) begin
            for (int i = 0; i < 256; i++)
                if (bytes2[b0 + 1 + i] !== (8'(i) ^ 8'h5A)) derr++;
        end else begin
            derr = 999;
        end
        check("wr data bytes", derr, 0);
        check("wr last byte", bytes2[b0 + 256], 8'hA5);
        check("wr strobes", strobes2 - s0, 256);
        check("wr single ack", wr_acks2 - w0, 1);
        check("wr ss one release", ss_rises2 - ss0, 1);
        repeat (3) @(negedge clk_sys);

        // Simultaneous requests: enable wins, write granted right after GAP; then reset at byte 100.
        b0 = bytes2.size(); e0 = en_acks2; w0 = wr_acks2;
        bus2.en_val = 1'b0; bus2.wr_line = 4'hA;
        bus2.en_req = 1'b1; bus2.wr_req = 1'b1;
        watch2(100, 1'b1, 1'b0, ack, idle);
        check("arb en ack cycle", ack, 34);
        check("arb idle cycle", idle, 38);
        check("arb en first", bytes2[b0], 8'h40);
        @(negedge clk_sys);
        check("arb wr regrant", bus2.busy, 1);
        bus2.wr_req = 1'b0;
        b0 = bytes2.size();
        for (int c = 0; c < 4000 && (bytes2.size() - b0) < 100; c++) @(negedge clk_sys);
        repeat (5) @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        check("mid reset ss/sck/busy", {bus2.spi_ss, bus2.spi_sck, bus2.busy}, 3'b100);
        reset = 1'b0;
        repeat (50) @(negedge clk_sys);
        check("arb wr cmd byte", bytes2[b0], 8'h2A);
        check("mid reset bytes", bytes2.size() - b0, 100);
        check("mid reset acks", {en_acks2 - e0, wr_acks2 - w0}, {32'd1, 32'd0});

        // Restart after reset begins again with the command byte.
        b0 = bytes2.size(); w0 = wr_acks2;
        bus2.wr_line = 4'h5; bus2.wr_req = 1'b1;
        watch2(9000, 1'b0, 1'b1, ack, idle);
        check("restart cmd byte", bytes2[b0], 8'h25);
        check("restart byte count", bytes2.size() - b0, 257);
        check("restart ack", {wr_acks2 - w0, ack}, {32'd1, 32'd8226});

`ifdef OSD_SEQ_ABORT_EN
        b0 = bytes2.size(); w0 = wr_acks2; e0 = aborted2;
        bus2.wr_line = 4'h1; bus2.wr_req = 1'b1;
        @(negedge clk_sys);
        bus2.wr_req = 1'b0;
        for (int c = 0; c < 2000 && (bytes2.size() - b0) < 10; c++) @(negedge clk_sys);
        repeat (5) @(negedge clk_sys);
        bus2.abort = 1'b1;
        repeat (5) @(negedge clk_sys);
        bus2.abort = 1'b0;
        watch2(2000, 1'b0, 1'b0, ack, idle);
        check("abort byte count", bytes2.size() - b0, 11);
        check("abort acks", {wr_acks2 - w0, aborted2 - e0}, {32'd1, 32'd1});
`endif

        // CLK_DIV=5 timing on an enable command 0x40.
        bus5.en_req = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_sys);
            if (c == 0) bus5.en_req = 1'b0;
            sck_t[c] = bus5.spi_sck;
            do_t[c]  = bus5.spi_do;
            ss_t[c]  = bus5.spi_ss;
        end
        bad = 0; nr = 0; sr2 = 8'h00;
        for (int c = 5; c < 95; c++) begin
            if (sck_t[c] && !sck_t[c-1]) begin
                int k;
                nr++;
                sr2 = {sr2[6:0], do_t[c]};
                k = 0;
                while (c + k < 100 && sck_t[c+k]) k++;
                if (k != 5) bad++;
                for (int j = -5; j < 5; j++) if (do_t[c+j] !== do_t[c]) bad++;
            end
            if (!sck_t[c] && sck_t[c-1] && !ss_t[c]) begin
                int k;
                k = 0;
                while (c + k < 100 && !sck_t[c+k]) k++;
                if (k != 5) bad++;
            end
        end
        check("div5 sck rises", nr, 8);
        check("div5 phase/do timing", bad, 0);
        check("div5 cmd byte", sr2, 8'h40);
        check("div5 ss window", {ss_t[0], ss_t[84], ss_t[85], ss_t[89]}, 4'b0011);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
